// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for an RV32I core: operand forwarding,
// ALU op translation and control-bit capture ahead of the execute stage.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic        exmem_wen,
  input  logic        memwb_wen,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] exmem_data,
  input  logic [31:0] memwb_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_illegal,
  output logic [31:0] ex_pc
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SEQ  = 4'd8;
  localparam logic [3:0] ALU_SNE  = 4'd9;
  localparam logic [3:0] ALU_SLT  = 4'd10;
  localparam logic [3:0] ALU_SGE  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;
  localparam logic [3:0] ALU_SGEU = 4'd13;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic [31:0] pc;
  } id_ex_t;

  id_ex_t      r_ex;
  id_ex_t      w_nx;
  logic [31:0] w_fwd1;
  logic [31:0] w_fwd2;
  logic [3:0]  w_br_op;
  logic        w_br_ok;

  // EX/MEM is younger than MEM/WB, so it takes precedence; x0 never forwards.
  function automatic logic [31:0] f_fwd(
    input logic [4:0]  a,
    input logic [31:0] d,
    input logic        em_wen,
    input logic [4:0]  em_rd,
    input logic [31:0] em_d,
    input logic        mw_wen,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_d
  );
    logic [31:0] v;
    v = d;
    if (a != 5'd0) begin
      if (em_wen && (em_rd == a))
        v = em_d;
      else if (mw_wen && (mw_rd == a))
        v = mw_d;
    end
    return v;
  endfunction

  function automatic logic [3:0] f_arith(
    input logic [2:0] f3,
    input logic       b5,
    input logic       is_reg
  );
    logic [3:0] o;
    o = ALU_ADD;
    unique case (f3)
      3'b000: o = (is_reg && b5) ? ALU_SUB : ALU_ADD;
      3'b001: o = ALU_SLL;
      3'b010: o = ALU_SLT;
      3'b011: o = ALU_SLTU;
      3'b100: o = ALU_XOR;
      3'b101: o = b5 ? ALU_SRA : ALU_SRL;
      3'b110: o = ALU_OR;
      3'b111: o = ALU_AND;
      default: o = ALU_ADD;
    endcase
    return o;
  endfunction

  always_comb begin
    w_fwd1 = f_fwd(rs1_addr, rs1_data,
                   exmem_wen, exmem_rd, exmem_data,
                   memwb_wen, memwb_rd, memwb_data);
    w_fwd2 = f_fwd(rs2_addr, rs2_data,
                   exmem_wen, exmem_rd, exmem_data,
                   memwb_wen, memwb_rd, memwb_data);
  end

  always_comb begin
    w_br_op = ALU_ADD;
    w_br_ok = 1'b1;
    unique case (funct3)
      3'b000: w_br_op = ALU_SEQ;
      3'b001: w_br_op = ALU_SNE;
      3'b100: w_br_op = ALU_SLT;
      3'b101: w_br_op = ALU_SGE;
      3'b110: w_br_op = ALU_SLTU;
      3'b111: w_br_op = ALU_SGEU;
      default: w_br_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_nx            = '0;
    w_nx.valid      = 1'b1;
    w_nx.rd         = rd_addr;
    w_nx.pc         = pc;
    w_nx.store_data = w_fwd2;
    unique case (opcode)
      OP_R: begin
        w_nx.alu_op   = f_arith(funct3, funct7b5, 1'b1);
        w_nx.op1      = w_fwd1;
        w_nx.op2      = w_fwd2;
        w_nx.regwrite = 1'b1;
      end
      OP_I: begin
        w_nx.alu_op   = f_arith(funct3, funct7b5, 1'b0);
        w_nx.op1      = w_fwd1;
        w_nx.op2      = imm;
        w_nx.regwrite = 1'b1;
      end
      OP_BR: begin
        if (w_br_ok) begin
          w_nx.alu_op = w_br_op;
          w_nx.op1    = w_fwd1;
          w_nx.op2    = w_fwd2;
          w_nx.branch = 1'b1;
        end else begin
          w_nx.illegal = 1'b1;
        end
      end
      OP_LD: begin
        w_nx.op1      = w_fwd1;
        w_nx.op2      = imm;
        w_nx.mem_read = 1'b1;
        w_nx.regwrite = 1'b1;
      end
      OP_ST: begin
        w_nx.op1       = w_fwd1;
        w_nx.op2       = imm;
        w_nx.mem_write = 1'b1;
      end
      OP_LUI: begin
        w_nx.op2      = imm;
        w_nx.regwrite = 1'b1;
      end
      OP_AUIPC: begin
        w_nx.op1      = pc;
        w_nx.op2      = imm;
        w_nx.regwrite = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        w_nx.op1      = pc;
        w_nx.op2      = 32'd4;
        w_nx.jump     = 1'b1;
        w_nx.regwrite = 1'b1;
      end
      default: begin
        w_nx.illegal = 1'b1;
      end
    endcase
    if (rd_addr == 5'd0)
      w_nx.regwrite = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ex <= '0;
    else if (flush)
      r_ex <= '0;
    else if (!stall)
      r_ex <= in_valid ? w_nx : '0;
  end

  assign ex_valid      = r_ex.valid;
  assign ex_alu_op     = r_ex.alu_op;
  assign ex_op1        = r_ex.op1;
  assign ex_op2        = r_ex.op2;
  assign ex_store_data = r_ex.store_data;
  assign ex_rd         = r_ex.rd;
  assign ex_regwrite   = r_ex.regwrite;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_branch     = r_ex.branch;
  assign ex_jump       = r_ex.jump;
  assign ex_illegal    = r_ex.illegal;
  assign ex_pc         = r_ex.pc;

endmodule
